lcm_unit: RTL and testbench

- Downstream stage of the gcd block. Consumes a gcd result together with the operand pair that produced it, and computes lcm(a,b) = (a / gcd) * b.
- Uses an XLEN-cycle restoring divider followed by an XLEN-cycle shift-add multiplier.
- Checks that the supplied gcd divides a exactly and flags an inconsistent result.
- Presents a 2*XLEN-bit result with the same ld/ready/valid handshake style as gcd.

---
 rtl/lcm_unit.sv | 155 +++++++++++++++
 tb/tb_lcm_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/lcm_unit.sv
// lcm_unit: lcm(a,b) = (a / gcd) * b via restoring divider then shift-add multiplier.
// Latency: 2*XLEN edges normal, 0 for zero operand / zero gcd, XLEN for inexact gcd.
// Backpressure: ready_o only in IDLE/DONE; result holds until ack_i or a new load.
// Optional build macro LCM_EARLY_EXIT_EN: MUL stops once the multiplier register empties.
module lcm_unit #(
   parameter int XLEN = 16
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              ld_i,
   input  logic [XLEN-1:0]   a_i,
   input  logic [XLEN-1:0]   b_i,
   input  logic [XLEN-1:0]   gcd_i,
   input  logic              ack_i,
   output logic              ready_o,
   output logic              valid_o,
   output logic [2*XLEN-1:0] lcm_o,
   output logic              err_o
);

   localparam int CW = $clog2(XLEN + 1);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_MUL, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_nx;
   logic [XLEN-1:0]   r_a;       // dividend, shifted out MSB first
   logic [XLEN-1:0]   r_g;       // divisor (supplied gcd)
   logic [XLEN-1:0]   r_q;       // quotient, shifted in LSB
   logic [XLEN:0]     r_rem;     // partial remainder
   logic [XLEN-1:0]   r_mult;    // holds b through DIV, then is the multiplier
   logic [2*XLEN-1:0] r_mcand;   // quotient, shifted left each MUL cycle
   logic [2*XLEN-1:0] r_acc;
   logic [2*XLEN-1:0] r_lcm;
   logic [CW-1:0]     r_cnt;
   logic              r_err;

   logic              w_accept;
   logic              w_fast;
   logic              w_gzero;
   logic [XLEN:0]     w_rem_sh;
   logic              w_ge;
   logic [XLEN:0]     w_rem_nx;
   logic [XLEN-1:0]   w_q_nx;
   logic [2*XLEN-1:0] w_acc_nx;
   logic [XLEN-1:0]   w_mult_nx;
   logic              w_last;
   logic              w_div_err;
   logic              w_mul_end;

   // The multiplier runs as b * quotient (b is the multiplier) so that the
   // early-exit length depends on b's highest set bit.
   assign w_accept  = ld_i & ready_o;
   assign w_fast    = (a_i == '0) || (b_i == '0);
   assign w_gzero   = (gcd_i == '0);
   assign w_rem_sh  = {r_rem[XLEN-1:0], r_a[XLEN-1]};
   assign w_ge      = (w_rem_sh >= {1'b0, r_g});
   assign w_rem_nx  = w_ge ? (w_rem_sh - {1'b0, r_g}) : w_rem_sh;
   assign w_q_nx    = {r_q[XLEN-2:0], w_ge};
   assign w_acc_nx  = r_mult[0] ? (r_acc + r_mcand) : r_acc;
   assign w_mult_nx = r_mult >> 1;
   assign w_last    = (r_cnt == LAST);
   assign w_div_err = w_last && (w_rem_nx != '0);
`ifdef LCM_EARLY_EXIT_EN
   assign w_mul_end = w_last || (w_mult_nx == '0);
`else
   assign w_mul_end = w_last;
`endif

   assign lcm_o = r_lcm;
   assign err_o = r_err;

   // State register
   always_ff @(posedge clk_i) begin
      if (reset_i) r_state <= S_IDLE;
      else         r_state <= w_state_nx;
   end

   // Next-state and handshake outputs
   always_comb begin
      w_state_nx = r_state;
      ready_o    = 1'b0;
      valid_o    = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready_o = 1'b1;
            if (ld_i) w_state_nx = (w_fast || w_gzero) ? S_DONE : S_DIV;
         end
         S_DIV: begin
            if (w_last) w_state_nx = w_div_err ? S_DONE : S_MUL;
         end
         S_MUL: begin
            if (w_mul_end) w_state_nx = S_DONE;
         end
         S_DONE: begin
            ready_o = 1'b1;
            valid_o = 1'b1;
            if (ld_i)       w_state_nx = (w_fast || w_gzero) ? S_DONE : S_DIV;
            else if (ack_i) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Datapath: operand capture, one divide or multiply step per cycle
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_a     <= '0;
         r_g     <= '0;
         r_q     <= '0;
         r_rem   <= '0;
         r_mult  <= '0;
         r_mcand <= '0;
         r_acc   <= '0;
         r_lcm   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_a     <= a_i;
         r_g     <= gcd_i;
         r_mult  <= b_i;
         r_q     <= '0;
         r_rem   <= '0;
         r_mcand <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_err   <= !w_fast && w_gzero;
         if (w_fast || w_gzero) r_lcm <= '0;
      end else if (r_state == S_DIV) begin
         r_a   <= r_a << 1;
         r_rem <= w_rem_nx;
         r_q   <= w_q_nx;
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            r_cnt   <= '0;
            r_mcand <= {{XLEN{1'b0}}, w_q_nx};
            if (w_div_err) begin
               r_lcm <= '0;
               r_err <= 1'b1;
            end
         end
      end else if (r_state == S_MUL) begin
         r_acc   <= w_acc_nx;
         r_mcand <= r_mcand << 1;
         r_mult  <= w_mult_nx;
         r_cnt   <= r_cnt + CW'(1);
         if (w_mul_end) begin
            r_lcm <= w_acc_nx;
            r_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lcm_unit.sv
// Testbench for lcm_unit: directed test-plan steps followed by randomized operations
// compared against an arithmetic reference model (result, error flag and latency).
module tb_lcm_unit;
   localparam int XLEN = 16;

   logic              clk_i = 1'b0;
   logic              reset_i;
   logic              ld_i;
   logic [XLEN-1:0]   a_i, b_i, gcd_i;
   logic              ack_i;
   logic              ready_o, valid_o, err_o;
   logic [2*XLEN-1:0] lcm_o;

   int n_checks = 0;
   int n_errors = 0;

   lcm_unit #(.XLEN(XLEN)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .ld_i(ld_i), .a_i(a_i), .b_i(b_i),
      .gcd_i(gcd_i), .ack_i(ack_i), .ready_o(ready_o), .valid_o(valid_o),
      .lcm_o(lcm_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint ref_lcm(input longint a, input longint b, input longint g);
      if (a == 0 || b == 0) return 0;
      if (g == 0 || (a % g) != 0) return 0;
      return (a / g) * b;
   endfunction

   function automatic bit ref_err(input longint a, input longint b, input longint g);
      if (a == 0 || b == 0) return 1'b0;
      return (g == 0) || ((a % g) != 0);
   endfunction

   function automatic int ref_lat(input longint a, input longint b, input longint g);
      int top;
      if (a == 0 || b == 0 || g == 0) return 0;
      if ((a % g) != 0) return XLEN;
`ifdef LCM_EARLY_EXIT_EN
      top = 0;
      for (int i = 0; i < XLEN; i++) if (((b >> i) & 1) != 0) top = i + 1;
      return XLEN + top;
`else
      top = XLEN;
      return XLEN + top;
`endif
   endfunction

   // Called at a negedge; returns at the negedge right after the accept edge.
   task automatic load(input int a, input int b, input int g);
      ld_i  = 1'b1;
      a_i   = XLEN'(a);
      b_i   = XLEN'(b);
      gcd_i = XLEN'(g);
      @(posedge clk_i);
      @(negedge clk_i);
      ld_i = 1'b0;
   endtask

   // Counts edges until valid_o, bounded.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!valid_o && lat < 200) begin
         @(negedge clk_i);
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input int a, input int b, input int g);
      int lat;
      load(a, b, g);
      wait_valid(lat);
      chk({tag, " latency"}, 64'(lat), 64'(ref_lat(a, b, g)));
      chk({tag, " valid"}, 64'(valid_o), 64'(1));
      chk({tag, " ready"}, 64'(ready_o), 64'(1));
      chk({tag, " lcm"}, 64'(lcm_o), 64'(ref_lcm(a, b, g)));
      chk({tag, " err"}, 64'(err_o), 64'(ref_err(a, b, g)));
   endtask

   initial begin
      int lat;
      int a, b, g, mode;
      reset_i = 1'b1; ld_i = 1'b0; ack_i = 1'b0;
      a_i = '0; b_i = '0; gcd_i = '0;
      repeat (2) @(negedge clk_i);
      reset_i = 1'b0;
      chk("reset ready", 64'(ready_o), 64'(1));
      chk("reset valid", 64'(valid_o), 64'(0));
      chk("reset lcm",   64'(lcm_o),   64'(0));
      chk("reset err",   64'(err_o),   64'(0));

      run_op("48_18_6", 48, 18, 6);
      ack_i = 1'b1;
      @(negedge clk_i);
      ack_i = 1'b0;
      chk("ack valid", 64'(valid_o), 64'(0));
      chk("ack ready", 64'(ready_o), 64'(1));
      chk("ack lcm hold", 64'(lcm_o), 64'(144));

      // Back-to-back loads, each issued while sitting in DONE.
      run_op("1701_199_1", 1701, 199, 1);
      run_op("22000_19900_100", 22000, 19900, 100);
      run_op("17_289_17", 17, 289, 17);
      run_op("zero_a", 0, 5, 5);
      run_op("zero_gcd", 9, 6, 0);
      run_op("bad_gcd", 48, 18, 5);

      // Loads during DIV and MUL must be ignored.
      load(48, 18, 6);
      repeat (3) @(negedge clk_i);
      ld_i = 1'b1; a_i = 16'd7; b_i = 16'd9; gcd_i = 16'd1;
      chk("busy div ready", 64'(ready_o), 64'(0));
      @(negedge clk_i);
      ld_i = 1'b0;
      repeat (14) @(negedge clk_i);
      ld_i = 1'b1; a_i = 16'd5; b_i = 16'd3; gcd_i = 16'd1;
      chk("busy mul ready", 64'(ready_o), 64'(0));
      @(negedge clk_i);
      ld_i = 1'b0;
      wait_valid(lat);
      chk("ignore ld latency", 64'(lat + 19), 64'(ref_lat(48, 18, 6)));
      chk("ignore ld lcm", 64'(lcm_o), 64'(144));
      chk("ignore ld err", 64'(err_o), 64'(0));

      // Reset mid-MUL.
      load(48, 18, 6);
      repeat (20) @(negedge clk_i);
      chk("pre-reset busy", 64'(ready_o), 64'(0));
      reset_i = 1'b1;
      @(negedge clk_i);
      reset_i = 1'b0;
      chk("midrst ready", 64'(ready_o), 64'(1));
      chk("midrst valid", 64'(valid_o), 64'(0));
      chk("midrst lcm",   64'(lcm_o),   64'(0));
      chk("midrst err",   64'(err_o),   64'(0));
      run_op("post_rst", 48, 18, 6);

      // Randomized operations.
      for (int i = 0; i < 40; i++) begin
         mode = int'($urandom_range(0, 4));
         g = int'($urandom_range(1, 255));
         case (mode)
            0: begin a = g * int'($urandom_range(1, 65535 / g)); b = int'($urandom_range(1, 65535)); end
            1: begin a = int'($urandom_range(1, 65535)); b = int'($urandom_range(1, 65535)); end
            2: begin a = int'($urandom_range(0, 1)) * int'($urandom_range(1, 65535)); b = (a == 0) ? int'($urandom_range(0, 65535)) : 0; end
            3: begin a = int'($urandom_range(1, 65535)); b = int'($urandom_range(1, 65535)); g = 0; end
            default: begin g = 1; a = 65535; b = int'($urandom_range(1, 65535)); end
         endcase
         if ($urandom_range(0, 1) == 1) begin
            ack_i = 1'b1;
            @(negedge clk_i);
            ack_i = 1'b0;
            chk("rand ack idle", 64'(valid_o), 64'(0));
         end
         run_op($sformatf("rand%0d", i), a, b, g);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
